modular_counter: RTL

Parametrised successor to the team's basic enable counter: a BITS-wide up/down counter with runtime terminal value, wrap or saturate mode, synchronous load, registered terminal-count pulse and an optional enable prescaler. Clocked on the falling edge of NEclk like the rest of the timing chain. Drives display/timebase logic that needs programmable-modulus counts instead of free-running binary wrap.

---
 rtl/modcnt_pkg.sv | 16 +
 rtl/modular_counter_if.sv | 30 +++
 rtl/modcnt_prescaler.sv | 33 +++
 rtl/modular_counter.sv | 78 +++++++
 4 files changed

// File: rtl/modcnt_pkg.sv
// modcnt_pkg: shared constants for the modular_counter block.
// Mode and direction encodings plus default widths.
package modcnt_pkg;

  localparam int DEF_BITS     = 29;
  localparam int DEF_PRE_BITS = 8;

  // Boundary behaviour selected by the sat input.
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Count direction selected by the up input.
  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

endpackage : modcnt_pkg

// File: rtl/modular_counter_if.sv
// modular_counter_if: control and status bundle of modular_counter.
// master = controlling logic, slave = the counter itself.
interface modular_counter_if
  import modcnt_pkg::*;
#(
  parameter int BITS     = DEF_BITS,
  parameter int PRE_BITS = DEF_PRE_BITS
);

  logic                Enable;
  logic                up;
  logic                load;
  logic [BITS-1:0]     load_val;
  logic [BITS-1:0]     limit;
  logic                sat;
  logic [PRE_BITS-1:0] prescale;
  logic [BITS-1:0]     count;
  logic                tc;

  modport master (
    output Enable, up, load, load_val, limit, sat, prescale,
    input  count, tc
  );

  modport slave (
    input  Enable, up, load, load_val, limit, sat, prescale,
    output count, tc
  );

endinterface : modular_counter_if

// File: rtl/modcnt_prescaler.sv
// modcnt_prescaler: qualifies Enable so a step occurs every prescale+1 enables.
// Only instantiated when MODCNT_PRESCALER_EN is defined.
module modcnt_prescaler
  import modcnt_pkg::*;
#(
  parameter int PRE_BITS = DEF_PRE_BITS
) (
  input  logic                NEclk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PRE_BITS-1:0] prescale,
  input  logic                clear,
  output logic                step
);

  logic [PRE_BITS-1:0] pre_cnt;

  // A count at or above prescale (prescale lowered mid-run) also steps.
  assign step = enable && (pre_cnt >= prescale);

  // Enable counter: cleared by reset/load, wraps to zero on each step.
  always_ff @(negedge NEclk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (reset || clear) begin
      pre_cnt <= '0;
    end else if (enable) begin
      if (pre_cnt >= prescale) pre_cnt <= '0;
      else                     pre_cnt <= pre_cnt + 1'b1;
    end
  end

endmodule : modcnt_prescaler

// File: rtl/modular_counter.sv
// modular_counter: BITS-wide up/down counter with runtime limit, wrap or
// saturate at the boundary, synchronous load and a registered tc pulse.
// Falling-edge clocked. Optional enable prescaler under MODCNT_PRESCALER_EN.
module modular_counter
  import modcnt_pkg::*;
#(
  parameter int BITS     = DEF_BITS,
  parameter int PRE_BITS = DEF_PRE_BITS
) (
  input  logic             NEclk,
  input  logic             reset,
  modular_counter_if.slave bus
);

  logic            step;
  logic [BITS-1:0] count_q;
  logic [BITS-1:0] count_nxt;
  logic            tc_q;
  logic            tc_nxt;

`ifdef MODCNT_PRESCALER_EN
  modcnt_prescaler #(.PRE_BITS(PRE_BITS)) u_prescaler (
    .NEclk    (NEclk),
    .reset    (reset),
    .enable   (bus.Enable),
    .prescale (bus.prescale),
    .clear    (bus.load),
    .step     (step)
  );
`else
  logic unused_prescale;

  assign step            = bus.Enable;
  assign unused_prescale = ^bus.prescale;
`endif

  // Next count and terminal flag: load > step > hold.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no
    // latch is inferred.
    count_nxt = count_q;
    tc_nxt    = 1'b0;
    if (bus.load) begin
      count_nxt = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
    end else if (step) begin
      if (bus.up == DIR_UP) begin
        if (count_q >= bus.limit) begin
          count_nxt = (bus.sat == MODE_SAT) ? bus.limit : '0;
          tc_nxt    = 1'b1;
        end else begin
          count_nxt = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          count_nxt = (bus.sat == MODE_SAT) ? '0 : bus.limit;
          tc_nxt    = 1'b1;
        end else begin
          count_nxt = count_q - 1'b1;
        end
      end
    end
  end

  // Count and tc registers, synchronous reset on the falling edge.
  always_ff @(negedge NEclk) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_nxt;
      tc_q    <= tc_nxt;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;

endmodule : modular_counter
